button_pulse_array: RTL and testbench

//   Parametrised successor to the single-key press-pulse FSM. Handles N_CH keys. Each channel provides:
//   - synchroniser, debouncer and one-cycle press pulse;
//   - one-cycle release pulse;
//   - optional per-channel auto-repeat while the key is held.

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_pulse_channel.sv | 129 ++++++++++++
 rtl/button_pulse_array.sv | 44 ++++
 tb/tb_button_pulse_array.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// button_pkg : shared FSM state type and counter-width helper for key channels
// Rev 1.0
// ============================================================================
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } btn_state_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_pulse_channel.sv
`default_nettype none
// ============================================================================
// button_pulse_channel : synchroniser, debouncer and press/repeat/release FSM
// Rev 1.0
// ============================================================================
module button_pulse_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic i_bi,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_bo,
  output logic o_bo_rel
);

  localparam int C_RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_RC_W   = cnt_width(C_RC_MAX);
  localparam int C_DB_W   = cnt_width(DEBOUNCE_CYCLES);

  localparam logic [C_DB_W-1:0] c_DB_LAST  = C_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_RC_W-1:0] c_RC_ARM   = C_RC_W'(REPEAT_DELAY - 2);
  localparam logic [C_RC_W-1:0] c_RC_SAT   = C_RC_W'(REPEAT_DELAY - 1);
  localparam logic [C_RC_W-1:0] c_RC_PLAST = C_RC_W'(REPEAT_PERIOD - 1);

  logic                   w_p;
  logic                   w_s;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [C_DB_W-1:0]      r_db_cnt;
  logic                   r_level;
  btn_state_t             r_state;
  logic [C_RC_W-1:0]      r_rc;
  logic                   r_bo;
  logic                   r_bo_rel;

  assign w_p = i_bi ^ (ACTIVE_LOW != 0);
  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_sync   <= '0;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_p};
      if (w_s != r_level) begin
        if (r_db_cnt == c_DB_LAST) begin
          r_level  <= w_s;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Release is tested first in every held state so it always beats a due repeat.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state  <= IDLE;
      r_rc     <= '0;
      r_bo     <= 1'b0;
      r_bo_rel <= 1'b0;
    end else begin
      r_bo     <= 1'b0;
      r_bo_rel <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_level) begin
            r_state <= PRESS;
            r_bo    <= 1'b1;
          end
        end
        PRESS: begin
          r_rc <= '0;
          if (r_level) begin
            r_state <= HOLD;
          end else begin
            r_state  <= IDLE;
            r_bo_rel <= 1'b1;
          end
        end
        HOLD: begin
          if (!r_level) begin
            r_state  <= IDLE;
            r_bo_rel <= 1'b1;
          end else if (i_repeat_en && (r_rc >= c_RC_ARM)) begin
            r_state <= REPEAT;
            r_bo    <= 1'b1;
            r_rc    <= '0;
          end else if (r_rc < c_RC_SAT) begin
            r_rc <= r_rc + 1'b1;
          end
        end
        REPEAT: begin
          if (!r_level) begin
            r_state  <= IDLE;
            r_bo_rel <= 1'b1;
          end else if (!i_repeat_en) begin
            // Parked saturated so re-enabling repeats on the very next cycle.
            r_state <= HOLD;
            r_rc    <= c_RC_SAT;
          end else if (r_rc == c_RC_PLAST) begin
            r_bo <= 1'b1;
            r_rc <= '0;
          end else begin
            r_rc <= r_rc + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_level  = r_level;
  assign o_bo     = r_bo;
  assign o_bo_rel = r_bo_rel;

endmodule
`default_nettype wire

// File: rtl/button_pulse_array.sv
`default_nettype none
// ============================================================================
// button_pulse_array : N_CH independent debounced key channels with auto-repeat
// Rev 1.0
// ============================================================================
module button_pulse_array
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic [N_CH-1:0] Bi,
  input  logic [N_CH-1:0] RepeatEn,
  output logic [N_CH-1:0] Level,
  output logic [N_CH-1:0] Bo,
  output logic [N_CH-1:0] BoRel
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_pulse_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .Clk        (Clk),
      .ResetN     (ResetN),
      .i_bi       (Bi[g]),
      .i_repeat_en(RepeatEn[g]),
      .o_level    (Level[g]),
      .o_bo       (Bo[g]),
      .o_bo_rel   (BoRel[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_array.sv
`default_nettype none
// ============================================================================
// tb_button_pulse_array : directed scenarios plus randomized run against a model
// Rev 1.0
// ============================================================================
module tb_button_pulse_array;

  localparam int N_CH   = 4;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int DELAY  = 16;
  localparam int PERIOD = 8;
  localparam int LAT    = SYNC + DEB + 1;

  logic            Clk = 1'b0;
  logic            ResetN;
  logic [N_CH-1:0] Bi;
  logic [N_CH-1:0] RepeatEn;
  logic [N_CH-1:0] Level;
  logic [N_CH-1:0] Bo;
  logic [N_CH-1:0] BoRel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: delayed samples, run-length debounce, pulse schedule by age.
  logic [N_CH-1:0] m_pipe [SYNC];
  int              m_run  [N_CH];
  int              m_age  [N_CH];
  int              m_due  [N_CH];
  bit              m_rep  [N_CH];
  logic [N_CH-1:0] m_level, m_bo, m_rel;

  button_pulse_array #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .ACTIVE_LOW(1)
  ) dut (
    .Clk(Clk), .ResetN(ResetN), .Bi(Bi), .RepeatEn(RepeatEn),
    .Level(Level), .Bo(Bo), .BoRel(BoRel)
  );

  always #5 Clk = ~Clk;

  task automatic model_edge(input logic [N_CH-1:0] bi, input logic [N_CH-1:0] ren,
                            input logic rstn);
    logic s;
    if (!rstn) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
      m_level = '0; m_bo = '0; m_rel = '0;
      for (int c = 0; c < N_CH; c++) begin
        m_run[c] = 0; m_age[c] = -1; m_due[c] = DELAY; m_rep[c] = 0;
      end
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      m_bo[c]  = 1'b0;
      m_rel[c] = 1'b0;
      if (m_age[c] < 0) begin
        if (m_level[c]) begin
          m_bo[c] = 1'b1; m_age[c] = 0; m_due[c] = DELAY; m_rep[c] = 0;
        end
      end else if (!m_level[c]) begin
        m_rel[c] = 1'b1; m_age[c] = -1;
      end else begin
        m_age[c]++;
        if (ren[c] && m_age[c] >= m_due[c]) begin
          m_bo[c] = 1'b1; m_due[c] = m_age[c] + PERIOD; m_rep[c] = 1;
        end else if (!ren[c] && m_rep[c]) begin
          m_due[c] = m_age[c] + 1;
        end
      end
      s = m_pipe[SYNC-1][c];
      if (s != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] >= DEB) begin
          m_level[c] = s; m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = ~bi;
  endtask

  task automatic step(input logic [N_CH-1:0] bi, input logic [N_CH-1:0] ren, input logic rstn);
    Bi = bi; RepeatEn = ren; ResetN = rstn;
    @(posedge Clk);
    model_edge(bi, ren, rstn);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'hF, 4'h0, 1'b1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(4'($urandom), 4'($urandom), 1'b0);
      n_checks++;
      if ({Level, Bo, BoRel} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset: Level/Bo/BoRel=%h required 000", {Level, Bo, BoRel});
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 4'h0, 1'b1);
      n_checks++;
      if ({Level, Bo, BoRel} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_idle: Level/Bo/BoRel=%h required 000", {Level, Bo, BoRel});
      end
    end
  endtask

  task automatic test_single_press();
    int lvl_k = -1, bo_k = -1, bo_n = 0, drop_k = -1, rel_k = -1, rel_n = 0, late_bo = 0;
    for (int k = 1; k <= 20; k++) begin
      step(4'b1110, 4'h0, 1'b1);
      if (Level[0] && lvl_k < 0) lvl_k = k;
      if (Bo[0]) begin bo_n++; if (bo_k < 0) bo_k = k; end
    end
    for (int k = 1; k <= 12; k++) begin
      step(4'hF, 4'h0, 1'b1);
      if (!Level[0] && drop_k < 0) drop_k = k;
      if (BoRel[0]) begin rel_n++; rel_k = k; end
      if (Bo[0]) late_bo++;
    end
    n_checks++;
    if (lvl_k != LAT - 1) begin n_fail++; $display("FAIL press_level_edge: got %0d required %0d", lvl_k, LAT - 1); end
    n_checks++;
    if (bo_k != LAT) begin n_fail++; $display("FAIL press_bo_edge: got %0d required %0d", bo_k, LAT); end
    n_checks++;
    if (bo_n != 1) begin n_fail++; $display("FAIL press_bo_count: got %0d required 1", bo_n); end
    n_checks++;
    if (drop_k != LAT - 1) begin n_fail++; $display("FAIL release_level_edge: got %0d required %0d", drop_k, LAT - 1); end
    n_checks++;
    if (rel_n != 1 || rel_k != LAT) begin
      n_fail++; $display("FAIL release_pulse: count %0d at edge %0d required 1 at %0d", rel_n, rel_k, LAT);
    end
    n_checks++;
    if (late_bo != 0) begin n_fail++; $display("FAIL release_no_bo: got %0d Bo pulses required 0", late_bo); end
  endtask

  task automatic test_bounce();
    int glitch = $urandom_range(1, DEB - 1);
    int seen = 0;
    for (int k = 1; k <= 16; k++) begin
      step((k <= glitch) ? 4'b1101 : 4'hF, 4'h0, 1'b1);
      if (Level[1] || Bo[1] || BoRel[1]) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL bounce_len%0d: %0d active cycles required 0", glitch, seen);
    end
  endtask

  // Hold length chosen so the next repeat falls on the release-pulse edge.
  task automatic test_auto_repeat();
    int exp_q[$], got_q[$];
    int t, rel_n = 0, rel_k = -1, rel_bo = 0;
    localparam int HOLD_N = 48;
    t = LAT;
    while (t <= HOLD_N) begin
      exp_q.push_back(t);
      t += (exp_q.size() == 1) ? DELAY : PERIOD;
    end
    for (int k = 1; k <= HOLD_N; k++) begin
      step(4'b1011, 4'b0100, 1'b1);
      if (Bo[2]) got_q.push_back(k);
      n_checks++;
      if ({Level, Bo, BoRel} !== {m_level, m_bo, m_rel}) begin
        n_fail++; $display("FAIL repeat_model k=%0d: got %h required %h", k, {Level, Bo, BoRel}, {m_level, m_bo, m_rel});
      end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL repeat_count: got %0d pulses required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL repeat_edge[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]);
      end
    end
    for (int k = 1; k <= 12; k++) begin
      step(4'hF, 4'b0100, 1'b1);
      if (BoRel[2]) begin rel_n++; rel_k = k; end
      if (Bo[2]) rel_bo++;
    end
    n_checks++;
    if (rel_n != 1 || rel_k != LAT) begin
      n_fail++; $display("FAIL repeat_release: count %0d at edge %0d required 1 at %0d", rel_n, rel_k, LAT);
    end
    n_checks++;
    if (rel_bo != 0) begin n_fail++; $display("FAIL repeat_release_priority: got %0d Bo required 0", rel_bo); end
  endtask

  task automatic test_repeat_drop();
    int bo_n = 0, rel_n = 0, rel_bo = 0;
    for (int k = 1; k <= 26; k++) begin
      step(4'b0111, 4'b1000, 1'b1);
      if (Bo[3]) bo_n++;
    end
    n_checks++;
    if (bo_n != 2) begin n_fail++; $display("FAIL drop_prearm: got %0d Bo required 2", bo_n); end
    bo_n = 0;
    for (int k = 1; k <= 30; k++) begin
      step(4'b0111, 4'b0000, 1'b1);
      if (Bo[3]) bo_n++;
    end
    n_checks++;
    if (bo_n != 0) begin n_fail++; $display("FAIL drop_no_repeat: got %0d Bo required 0", bo_n); end
    for (int k = 1; k <= 12; k++) begin
      step(4'hF, 4'h0, 1'b1);
      if (BoRel[3]) rel_n++;
      if (Bo[3]) rel_bo++;
    end
    n_checks++;
    if (rel_n != 1 || rel_bo != 0) begin
      n_fail++; $display("FAIL drop_release: BoRel %0d Bo %0d required 1 and 0", rel_n, rel_bo);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int bo_k = -1;
    for (int k = 1; k <= 30; k++) step(4'b1011, 4'b0100, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(4'b1011, 4'b0100, 1'b0);
      n_checks++;
      if ({Level, Bo, BoRel} !== 12'h000) begin
        n_fail++; $display("FAIL midreset_out: got %h required 000", {Level, Bo, BoRel});
      end
    end
    for (int k = 1; k <= 12 && bo_k < 0; k++) begin
      step(4'b1011, 4'b0100, 1'b1);
      if (Bo[2]) bo_k = k;
    end
    n_checks++;
    if (bo_k != LAT) begin n_fail++; $display("FAIL midreset_repress: Bo edge %0d required %0d", bo_k, LAT); end
    idle(12);
  endtask

  task automatic test_all_keys();
    int bo_total = 0, bo_at_lat = -1;
    int rel_at[N_CH], rel_k[N_CH], rel_n[N_CH];
    logic [N_CH-1:0] bi;
    for (int k = 1; k <= 20; k++) begin
      step(4'h0, 4'h0, 1'b1);
      bo_total += $countones(Bo);
      if (k == LAT) bo_at_lat = int'(Bo);
    end
    n_checks++;
    if (bo_at_lat != 15) begin n_fail++; $display("FAIL all_press_bo: got %0h required f", bo_at_lat); end
    n_checks++;
    if (bo_total != N_CH) begin n_fail++; $display("FAIL all_press_count: got %0d required %0d", bo_total, N_CH); end
    for (int c = 0; c < N_CH; c++) begin
      rel_at[c] = 1 + 3 * c + $urandom_range(0, 2); rel_k[c] = -1; rel_n[c] = 0;
    end
    for (int k = 1; k <= 30; k++) begin
      for (int c = 0; c < N_CH; c++) bi[c] = (k >= rel_at[c]);
      step(bi, 4'h0, 1'b1);
      for (int c = 0; c < N_CH; c++) if (BoRel[c]) begin rel_n[c]++; rel_k[c] = k; end
    end
    for (int c = 0; c < N_CH; c++) begin
      n_checks++;
      if (rel_n[c] != 1 || rel_k[c] != rel_at[c] + LAT - 1) begin
        n_fail++; $display("FAIL stagger_rel ch%0d: count %0d edge %0d required 1 at %0d", c, rel_n[c], rel_k[c], rel_at[c] + LAT - 1);
      end
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] key = '0, ren = '0, bi;
    logic rstn;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 39) == 0) key[c] = ~key[c];
        if ($urandom_range(0, 49) == 0) ren[c] = ~ren[c];
        bi[c] = ~key[c] ^ ($urandom_range(0, 29) == 0);
      end
      rstn = ($urandom_range(0, 499) != 0);
      step(bi, ren, rstn);
      n_checks++;
      if ({Level, Bo, BoRel} !== {m_level, m_bo, m_rel}) begin
        n_fail++; $display("FAIL random k=%0d: Level/Bo/BoRel=%h required %h", k, {Level, Bo, BoRel}, {m_level, m_bo, m_rel});
      end
    end
  endtask

  initial begin
    ResetN = 1'b0; Bi = 4'hF; RepeatEn = 4'h0;
    test_reset();
    idle(4);
    test_single_press();
    idle(4);
    test_bounce();
    idle(4);
    test_auto_repeat();
    idle(4);
    test_repeat_drop();
    idle(4);
    test_reset_mid_repeat();
    test_all_keys();
    idle(12);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
